// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
//
// Read-side consumer of an 8-bit FIFO. Pops bytes whenever the FIFO is not
// empty, packs them little-endian into 32-bit words and presents each word on
// a valid/ready output. A partial word is flushed with its byte count once the
// FIFO has stayed empty for TIMEOUT consecutive idle cycles.
//
// Ports
//   rd_clk      clock shared with the FIFO read side
//   rd_rst      asynchronous, active-high reset
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  pop request (combinational, never high while fifo_empty)
//   out_data    packed word, byte k in bits [8k+7:8k]
//   out_bytes   number of valid bytes in out_data (1..4)
//   out_valid   out_data/out_bytes valid
//   out_ready   downstream accepts when out_valid && out_ready
// -----------------------------------------------------------------------------
module fifo_word_packer #(
    parameter int TIMEOUT = 16
) (
    input  logic        rd_clk,
    input  logic        rd_rst,
    input  logic [7:0]  fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

    logic [7:0]  acc [4];      // accumulator byte slots
    logic [2:0]  acc_cnt;      // bytes held in the accumulator, 0..4
    logic        inflight;     // a pop was issued last cycle; data lands now
    logic [7:0]  timer;        // idle cycles with a partial word held

    logic        timed_out;
    logic        out_free;
    logic        xfer;
    logic [3:0]  pending;
    logic [1:0]  cap_slot;
    logic [31:0] acc_word;

    // NOTE: every signal driven here gets a default before any condition so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        timed_out = (timer == TIMEOUT_V);
        out_free  = !out_valid || out_ready;
        xfer      = ((acc_cnt == 3'd4) || timed_out) && (acc_cnt != 3'd0) && out_free;

        // Bytes already committed to the accumulator, including the one in flight.
        pending   = {1'b0, acc_cnt} + {3'b000, inflight};

        // A read in an xfer cycle is allowed: it lands in the cleared accumulator.
        // Reads are held off while timed out so the flush stays atomic.
        fifo_rd_en = !rd_rst && !fifo_empty && !timed_out && ((pending < 4'd4) || xfer);

        // A capture coinciding with xfer (not reachable in normal operation)
        // would start the next word.
        cap_slot = xfer ? 2'd0 : acc_cnt[1:0];

        // Unused byte lanes are forced to zero.
        acc_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < acc_cnt) begin
                acc_word[8*k +: 8] = acc[k];
            end
        end
    end

    // NOTE: the accumulator data slots are not reset; acc_cnt alone defines
    // which slots are meaningful and stale lanes are masked off above.
    always_ff @(posedge rd_clk) begin
        if (inflight) begin
            acc[cap_slot] <= fifo_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            acc_cnt   <= 3'd0;
            inflight  <= 1'b0;
            timer     <= 8'd0;
            out_data  <= 32'd0;
            out_bytes <= 3'd0;
            out_valid <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;

            if (xfer) begin
                acc_cnt <= {2'b00, inflight};
            end else if (inflight) begin
                acc_cnt <= acc_cnt + 3'd1;
            end

            // Count only true idle: partial word, nothing in flight, FIFO empty.
            if (xfer || inflight || (acc_cnt == 3'd0)) begin
                timer <= 8'd0;
            end else if (fifo_empty && !timed_out && (acc_cnt != 3'd4)) begin
                timer <= timer + 8'd1;
            end

            if (xfer) begin
                out_data  <= acc_word;
                out_bytes <= acc_cnt;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Read-side consumer of the 8-bit async FIFO; runs entirely in the FIFO read clock domain.
- Pops bytes whenever the FIFO is not empty and packs them little-endian into 32-bit words.
- Presents each word on a valid/ready output with backpressure.
- Flushes a partial word, with a byte count, after the FIFO has stayed empty for TIMEOUT cycles.

Parameters:
- TIMEOUT, 16: consecutive idle cycles (partial word held, FIFO empty, no read in flight) before a partial word is flushed; legal range 1..255.

Ports:
- rd_clk  in  1  clock shared with the FIFO read side.
- rd_rst  in  1  reset, asynchronous, active-high.
- fifo_data  in  8  FIFO read data; valid in the cycle after fifo_rd_en was high.
- fifo_empty  in  1  FIFO empty flag (rd_clk domain).
- fifo_rd_en  out  1  pop request to the FIFO.
- out_data  out  32  packed word; byte k occupies bits [8k+7:8k].
- out_bytes  out  3  number of valid bytes in out_data, 1..4.
- out_valid  out  1  out_data/out_bytes valid.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.

Behaviour:
- Reset: one clock, rd_clk; reset rd_rst is asynchronous and active-high. All state clears immediately: fifo_rd_en=0, out_valid=0, out_data=0, out_bytes=0.
- Reset cleanup: accumulator count, in-flight flag and timer clear to 0. A byte in flight when reset asserts is discarded.
- Read latency: fixed at 1. `inflight` is set in the cycle after fifo_rd_en=1. fifo_data is captured at the end of that cycle into accumulator slot acc_cnt, and acc_cnt increments.
- Transfer condition: `xfer` = (acc_cnt==4 || timer==TIMEOUT) && acc_cnt>0 && (!out_valid || out_ready).
- Transfer action: the accumulator (unused bytes forced to 0) and acc_cnt are registered into out_data/out_bytes, out_valid is set, and acc_cnt and timer clear.
- Read issue: fifo_rd_en = !fifo_empty && timer!=TIMEOUT && ((acc_cnt + inflight) < 4 || xfer). fifo_rd_en is combinational and is never high while fifo_empty=1.
- Read during transfer: a read issued in an xfer cycle lands in the freshly cleared accumulator as byte 0.
- Output handshake:
  - out_valid stays high, with out_data/out_bytes stable, until out_valid && out_ready.
  - If no xfer occurs in the accept cycle, out_valid drops the next cycle.
  - Accept and xfer in the same cycle load the new word back-to-back with out_valid held high.
- Timer:
  - Increments, saturating at TIMEOUT, each cycle with acc_cnt in 1..3, inflight=0 and fifo_empty=1.
  - Clears on any byte capture, on xfer, or when acc_cnt==0.
  - While timer==TIMEOUT, reads are blocked until the partial word transfers. This keeps the flush atomic even if the FIFO becomes non-empty while the output is stalled.
- Latency: first fifo_rd_en in cycle 0 with the FIFO continuously non-empty and out_ready=1:
  - bytes are captured at the ends of cycles 1..4;
  - xfer happens in cycle 5;
  - out_valid=1 in cycle 6.
- Throughput: 4 bytes per 5 cycles sustained; the one idle read cycle is the one where acc_cnt=3 and inflight=1.
- Full backpressure: with the output word held and the accumulator full, reads stop. At most 8 bytes are buffered and no byte is dropped or reordered.
- Byte order:
  - First popped byte goes to bits [7:0].
  - FIFO order is preserved across words, flushes and stalls.

Test Plan:
1. FIFO preloaded 0x11,0x22,0x33,0x44, out_ready=1 -> single beat out_data=0x44332211, out_bytes=4, out_valid high exactly 1 cycle, 6 cycles after first fifo_rd_en.
2. Bytes 0xAA,0xBB then FIFO empty, TIMEOUT=16 -> no output for 15 idle cycles; then out_data=0x0000BBAA, out_bytes=2.
3. 12 bytes 0x00..0x0B, out_ready=0 for 30 cycles -> fifo_rd_en stops after 8 pops; out_data holds 0x03020100 stable. On release, words 0x03020100, 0x07060504, 0x0B0A0908 appear in order, all out_bytes=4.
4. fifo_empty toggling every cycle over 8 bytes -> fifo_rd_en never high while fifo_empty=1; words 0x03020100, 0x07060504.
5. rd_rst pulsed asynchronously mid-cycle with acc_cnt=2 -> all outputs 0 before the next edge. Next pushed 0x55,0x66,0x77,0x88 yield 0x88776655.
6. With 1 byte held, a second byte arrives when timer=TIMEOUT-1 -> timer clears, no flush. After TIMEOUT more idle cycles, out_bytes=2.
